ifid_skid_stage: RTL

- Parametrised IF/ID pipeline stage using a valid/ready handshake and a 2-entry skid buffer.
- Carries instruction, PC and PC+4 from fetch to decode.
- `in_ready` is driven only from internal state, so decode backpressure never forms a combinational path into fetch.
- Flushes insert a NOP bubble; the stage never outputs zero.

---
 rtl/ifid_skid_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ifid_skid_stage.sv
// rtl/ifid_skid_stage.sv - IF/ID pipeline stage with 2-entry skid buffer (optional counters: IFID_PERF_CNT_EN)
module ifid_skid_stage #(
  parameter int              XLEN    = 32,
  parameter int              INS_W   = 32,
  parameter logic [INS_W-1:0] NOP_INS = INS_W'(32'h00000013),
  parameter int              CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INS_W-1:0] in_ins,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_pc_plus4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INS_W-1:0] out_ins,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc_plus4,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Occupancy: EMPTY = nothing held, ONE = main only, FULL = main and skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic consume;

  logic load_main_in;
  logic load_skid_in;
  logic move_skid;

  logic [INS_W-1:0] main_ins, skid_ins;
  logic [XLEN-1:0]  main_pc, skid_pc;
  logic [XLEN-1:0]  main_pc4, skid_pc4;

  assign main_valid = (state != ST_EMPTY);
  assign skid_valid = (state == ST_FULL);

  // Ready comes only from registered occupancy, so decode backpressure never reaches fetch combinationally.
  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // Occupancy register; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next occupancy and payload steering; flush drops everything, including a same-cycle accept.
  always_comb begin
    state_nxt    = state;
    load_main_in = 1'b0;
    load_skid_in = 1'b0;
    move_skid    = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt    = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            state_nxt    = ST_ONE;
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt    = ST_FULL;
            load_skid_in = 1'b1;
          end else if (consume) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_nxt = ST_ONE;
            move_skid = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // Main payload: loads from fetch or from skid, otherwise holds.
  always_ff @(posedge CLK) begin
    if (reset) begin
      main_ins <= NOP_INS;
      main_pc  <= '0;
      main_pc4 <= '0;
    end else if (load_main_in) begin
      main_ins <= in_ins;
      main_pc  <= in_pc;
      main_pc4 <= in_pc_plus4;
    end else if (move_skid) begin
      main_ins <= skid_ins;
      main_pc  <= skid_pc;
      main_pc4 <= skid_pc4;
    end
  end

  // Skid payload: captures the entry that arrived while decode was stalled.
  always_ff @(posedge CLK) begin
    if (reset) begin
      skid_ins <= NOP_INS;
      skid_pc  <= '0;
      skid_pc4 <= '0;
    end else if (load_skid_in) begin
      skid_ins <= in_ins;
      skid_pc  <= in_pc;
      skid_pc4 <= in_pc_plus4;
    end
  end

  // Bubble values whenever nothing valid sits in main.
  always_comb begin
    out_ins      = NOP_INS;
    out_pc       = '0;
    out_pc_plus4 = '0;
    if (main_valid) begin
      out_ins      = main_ins;
      out_pc       = main_pc;
      out_pc_plus4 = main_pc4;
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Saturating event counters; flush leaves them alone, only reset clears.
  always_ff @(posedge CLK) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush && (main_valid || skid_valid) && (flush_q != {CNT_W{1'b1}})) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
